// File: rtl/waveform_to_pipe_if.sv
// Sample-capture and okBTPipeOut handshake bundle for waveform_to_pipe.
// The master side drives samples and host reads; the slave side is the FIFO.
interface waveform_to_pipe_if;
   logic        sample_strobe;
   logic [31:0] sample_data;
   logic        ep_read;
   logic        ep_blockstrobe;
   logic [15:0] ep_datain;
   logic        ep_ready;

   modport master (
      output sample_strobe,
      output sample_data,
      output ep_read,
      output ep_blockstrobe,
      input  ep_datain,
      input  ep_ready
   );

   modport slave (
      input  sample_strobe,
      input  sample_data,
      input  ep_read,
      input  ep_blockstrobe,
      output ep_datain,
      output ep_ready
   );
endinterface

// File: rtl/waveform_to_pipe.sv
// Captures 32-bit samples into a FIFO and streams them to the host as 16-bit
// words (low half first) through an okBTPipeOut-style read/ready handshake.
module waveform_to_pipe #(
   parameter int AW          = 10,
   parameter int BLOCK_WORDS = 512
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                enable,
   waveform_to_pipe_if.slave   pipe,
   output logic [AW:0]         fill_cnt,
   output logic [15:0]         overflow_cnt,
   output logic [15:0]         underflow_cnt,
   output logic [15:0]         block_cnt,
   output logic                overflow
);

   localparam int              DEPTH       = 1 << AW;
   localparam logic [AW:0]     FULL_LEVEL  = (AW+1)'(DEPTH);
   localparam logic [AW+1:0]   BLOCK_LEVEL = (AW+2)'(BLOCK_WORDS);

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   fill_q, fill_d;
   logic          half_q, half_d;
   logic [15:0]   dataOut_q, dataOut_d;
   logic          ready_q, ready_d;
   logic [15:0]   ovfCnt_q, ovfCnt_d;
   logic [15:0]   undCnt_q, undCnt_d;
   logic [15:0]   blkCnt_q, blkCnt_d;
   logic          ovfFlag_q, ovfFlag_d;

   logic          isFull, isEmpty, capture, doPush, doDrop, doRead, doPop, emptyRead;
   logic [31:0]   headWord;
   logic [AW+1:0] wordsLeft;

   assign isFull    = (fill_q == FULL_LEVEL);
   assign isEmpty   = (fill_q == '0);
   assign capture   = pipe.sample_strobe & enable & ~clear;
   assign doPush    = capture & ~isFull;
   assign doDrop    = capture & isFull;
   assign doRead    = pipe.ep_read & ~isEmpty & ~clear;
   assign doPop     = doRead & half_q;
   assign emptyRead = pipe.ep_read & isEmpty & ~clear;

   always_comb begin
      wrPtr_d  = wrPtr_q + AW'(doPush);
      rdPtr_d  = rdPtr_q + AW'(doPop);
      fill_d   = fill_q + (AW+1)'(doPush) - (AW+1)'(doPop);
      half_d   = half_q ^ doRead;
      if (clear) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         fill_d  = '0;
         half_d  = 1'b0;
      end

      // Output word is computed from next-state so it is valid right after a read;
      // a sample landing in the head slot this cycle is forwarded past the RAM.
      headWord = (doPush && (wrPtr_q == rdPtr_d)) ? pipe.sample_data : mem[rdPtr_d];
      if (fill_d == '0)
         dataOut_d = 16'h0000;
      else
         dataOut_d = half_d ? headWord[31:16] : headWord[15:0];

      wordsLeft = {fill_d, 1'b0} - (AW+2)'(half_d);
      ready_d   = (wordsLeft >= BLOCK_LEVEL);

      ovfCnt_d  = ovfCnt_q;
      undCnt_d  = undCnt_q;
      blkCnt_d  = blkCnt_q + 16'(pipe.ep_blockstrobe);
      ovfFlag_d = ovfFlag_q | doDrop;
      if (doDrop && (ovfCnt_q != 16'hFFFF))
         ovfCnt_d = ovfCnt_q + 16'd1;
      if (emptyRead && (undCnt_q != 16'hFFFF))
         undCnt_d = undCnt_q + 16'd1;
      if (clear) begin
         ovfCnt_d  = '0;
         undCnt_d  = '0;
         blkCnt_d  = '0;
         ovfFlag_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         fill_q    <= '0;
         half_q    <= 1'b0;
         dataOut_q <= '0;
         ready_q   <= 1'b0;
         ovfCnt_q  <= '0;
         undCnt_q  <= '0;
         blkCnt_q  <= '0;
         ovfFlag_q <= 1'b0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         fill_q    <= fill_d;
         half_q    <= half_d;
         dataOut_q <= dataOut_d;
         ready_q   <= ready_d;
         ovfCnt_q  <= ovfCnt_d;
         undCnt_q  <= undCnt_d;
         blkCnt_q  <= blkCnt_d;
         ovfFlag_q <= ovfFlag_d;
      end
   end

   // Sample storage has no reset; contents are only trusted behind fill_q.
   always_ff @(posedge clk) begin
      if (doPush)
         mem[wrPtr_q] <= pipe.sample_data;
   end

   assign pipe.ep_datain = dataOut_q;
   assign pipe.ep_ready  = ready_q;
   assign fill_cnt       = fill_q;
   assign overflow_cnt   = ovfCnt_q;
   assign underflow_cnt  = undCnt_q;
   assign block_cnt      = blkCnt_q;
   assign overflow       = ovfFlag_q;

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Self-checking bench for waveform_to_pipe with a small FIFO (AW=2) and
// 4-word blocks; a word-queue scoreboard predicts every host read.
module tb_waveform_to_pipe;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int BW    = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clear;
   logic          enable;
   logic [AW:0]   fillCnt;
   logic [15:0]   ovfCnt, undCnt, blkCnt;
   logic          ovfFlag;

   waveform_to_pipe_if bus ();

   waveform_to_pipe #(.AW(AW), .BLOCK_WORDS(BW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (clear),
      .enable        (enable),
      .pipe          (bus),
      .fill_cnt      (fillCnt),
      .overflow_cnt  (ovfCnt),
      .underflow_cnt (undCnt),
      .block_cnt     (blkCnt),
      .overflow      (ovfFlag)
   );

   always #5 clk = ~clk;

   int          testsRun    = 0;
   int          testsFailed = 0;
   logic [15:0] expQ[$];
   int          mFill, mHalf, mOvf, mUnd;
   logic        mOvfFlag;

   task automatic modelReset();
      expQ.delete();
      mFill    = 0;
      mHalf    = 0;
      mOvf     = 0;
      mUnd     = 0;
      mOvfFlag = 1'b0;
   endtask

   function automatic logic expReady();
      return ((2 * mFill - mHalf) >= BW);
   endfunction

   // One clock of stimulus, entered and left at a falling edge. The word the
   // host consumes is sampled before the edge; the model predicts it.
   task automatic cycle(input logic strobe, input logic [31:0] data, input logic rd,
                        input logic clr, output logic [15:0] gotWord, output logic [15:0] expWord);
      logic wasFull;
      gotWord = bus.ep_datain;
      expWord = 16'h0000;
      if (clr) begin
         modelReset();
      end else begin
         wasFull = (mFill == DEPTH);
         if (rd) begin
            if (mFill == 0) begin
               if (mUnd < 65535) mUnd++;
            end else begin
               expWord = expQ.pop_front();
               if (mHalf == 1) begin
                  mHalf = 0;
                  mFill--;
               end else begin
                  mHalf = 1;
               end
            end
         end
         if (strobe && enable) begin
            if (wasFull) begin
               if (mOvf < 65535) mOvf++;
               mOvfFlag = 1'b1;
            end else begin
               expQ.push_back(data[15:0]);
               expQ.push_back(data[31:16]);
               mFill++;
            end
         end
      end
      bus.sample_strobe = strobe;
      bus.sample_data   = data;
      bus.ep_read       = rd;
      clear             = clr;
      @(negedge clk);
      bus.sample_strobe = 1'b0;
      bus.ep_read       = 1'b0;
      clear             = 1'b0;
   endtask

   task automatic pushOne(input logic [31:0] data);
      logic [15:0] g, e;
      cycle(1'b1, data, 1'b0, 1'b0, g, e);
   endtask

   task automatic readOne(output logic [15:0] got, output logic [15:0] exp);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, got, exp);
   endtask

   task automatic test_reset();
      reset_n            = 1'b0;
      clear              = 1'b0;
      enable             = 1'b0;
      bus.sample_strobe  = 1'b0;
      bus.sample_data    = 32'h0;
      bus.ep_read        = 1'b0;
      bus.ep_blockstrobe = 1'b0;
      modelReset();
      #12;
      testsRun += 7;
      if (fillCnt !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_fill got=%0d exp=0", fillCnt); end
      if (bus.ep_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready got=%b exp=0", bus.ep_ready); end
      if (bus.ep_datain !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_datain got=%h exp=0000", bus.ep_datain); end
      if (ovfCnt !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_ovfcnt got=%0d exp=0", ovfCnt); end
      if (undCnt !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_undcnt got=%0d exp=0", undCnt); end
      if (blkCnt !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_blkcnt got=%0d exp=0", blkCnt); end
      if (ovfFlag !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovfflag got=%b exp=0", ovfFlag); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [15:0] seq[6];
      logic [15:0] g, e;
      seq = '{16'h0000, 16'h3F80, 16'h0FDB, 16'h4049, 16'h0001, 16'h0000};
      enable = 1'b1;
      pushOne(32'h3F80_0000);
      pushOne(32'h4049_0FDB);
      pushOne(32'h0000_0001);
      testsRun++;
      if (fillCnt !== 3'd3) begin testsFailed++; $display("[TB] FAIL basic_fill got=%0d exp=3", fillCnt); end
      for (int i = 0; i < 6; i++) begin
         readOne(g, e);
         testsRun += 2;
         if (g !== e) begin testsFailed++; $display("[TB] FAIL basic_sb%0d got=%h exp=%h", i, g, e); end
         if (g !== seq[i]) begin testsFailed++; $display("[TB] FAIL basic_seq%0d got=%h exp=%h", i, g, seq[i]); end
      end
      testsRun += 2;
      if (fillCnt !== 3'd0) begin testsFailed++; $display("[TB] FAIL basic_drain got=%0d exp=0", fillCnt); end
      if (undCnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL basic_und got=%0d exp=0", undCnt); end
   endtask

   task automatic test_ready();
      logic [15:0] g, e;
      pushOne(32'hA5A5_1234);
      testsRun += 2;
      if (bus.ep_datain !== 16'h1234) begin testsFailed++; $display("[TB] FAIL ready_latency got=%h exp=1234", bus.ep_datain); end
      if (bus.ep_ready !== expReady()) begin testsFailed++; $display("[TB] FAIL ready_one got=%b exp=%b", bus.ep_ready, expReady()); end
      pushOne(32'h5A5A_9876);
      testsRun++;
      if (bus.ep_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL ready_two got=%b exp=1", bus.ep_ready); end
      readOne(g, e);
      testsRun += 2;
      if (g !== e) begin testsFailed++; $display("[TB] FAIL ready_word got=%h exp=%h", g, e); end
      if (bus.ep_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_three got=%b exp=0", bus.ep_ready); end
      for (int i = 0; i < 3; i++) begin
         readOne(g, e);
         testsRun++;
         if (g !== e) begin testsFailed++; $display("[TB] FAIL ready_drain%0d got=%h exp=%h", i, g, e); end
      end
   endtask

   task automatic test_enable();
      logic [15:0] g, e;
      enable = 1'b0;
      cycle(1'b1, 32'hFFFF_EEEE, 1'b0, 1'b0, g, e);
      testsRun += 2;
      if (fillCnt !== 3'(mFill)) begin testsFailed++; $display("[TB] FAIL enable_fill got=%0d exp=%0d", fillCnt, mFill); end
      if (bus.ep_datain !== 16'h0) begin testsFailed++; $display("[TB] FAIL enable_datain got=%h exp=0000", bus.ep_datain); end
      enable = 1'b1;
   endtask

   task automatic test_overflow();
      logic [15:0] g, e;
      for (int k = 1; k <= 5; k++)
         pushOne({16'(16'hC000 + k), 16'(k)});
      testsRun += 3;
      if (fillCnt !== 3'd4) begin testsFailed++; $display("[TB] FAIL ovf_fill got=%0d exp=4", fillCnt); end
      if (ovfCnt !== 16'd1) begin testsFailed++; $display("[TB] FAIL ovf_cnt got=%0d exp=1", ovfCnt); end
      if (ovfFlag !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_flag got=%b exp=1", ovfFlag); end
      for (int i = 0; i < 8; i++) begin
         readOne(g, e);
         testsRun++;
         if (g !== e) begin testsFailed++; $display("[TB] FAIL ovf_word%0d got=%h exp=%h", i, g, e); end
      end
      testsRun++;
      if (fillCnt !== 3'd0) begin testsFailed++; $display("[TB] FAIL ovf_drain got=%0d exp=0", fillCnt); end
   endtask

   task automatic test_full_pop();
      logic [15:0] g, e;
      int guard;
      for (int k = 0; k < 4; k++)
         pushOne({16'(16'h7700 + k), 16'(16'h3300 + k)});
      readOne(g, e);
      cycle(1'b1, 32'hBAD0_BAD1, 1'b1, 1'b0, g, e);
      testsRun += 3;
      if (g !== e) begin testsFailed++; $display("[TB] FAIL fullpop_word got=%h exp=%h", g, e); end
      if (fillCnt !== 3'd3) begin testsFailed++; $display("[TB] FAIL fullpop_fill got=%0d exp=3", fillCnt); end
      if (ovfCnt !== 16'(mOvf)) begin testsFailed++; $display("[TB] FAIL fullpop_ovf got=%0d exp=%0d", ovfCnt, mOvf); end
      readOne(g, e);
      readOne(g, e);
      readOne(g, e);
      cycle(1'b1, 32'h1357_2468, 1'b1, 1'b0, g, e);
      testsRun += 2;
      if (g !== e) begin testsFailed++; $display("[TB] FAIL pushpop_word got=%h exp=%h", g, e); end
      if (fillCnt !== 3'd2) begin testsFailed++; $display("[TB] FAIL pushpop_fill got=%0d exp=2", fillCnt); end
      guard = 0;
      while (expQ.size() > 0 && guard < 20) begin
         readOne(g, e);
         guard++;
         testsRun++;
         if (g !== e) begin testsFailed++; $display("[TB] FAIL pushpop_drain%0d got=%h exp=%h", guard, g, e); end
      end
      testsRun++;
      if (fillCnt !== 3'd0) begin testsFailed++; $display("[TB] FAIL pushpop_empty got=%0d exp=0", fillCnt); end
   endtask

   task automatic test_clear();
      logic [15:0] g, e;
      cycle(1'b0, 32'h0, 1'b0, 1'b1, g, e);
      pushOne(32'hAAAA_0001);
      pushOne(32'hBBBB_0002);
      pushOne(32'hCCCC_0003);
      readOne(g, e);
      cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, g, e);
      testsRun += 4;
      if (fillCnt !== 3'd0) begin testsFailed++; $display("[TB] FAIL clear_fill got=%0d exp=0", fillCnt); end
      if (bus.ep_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_ready got=%b exp=0", bus.ep_ready); end
      if (bus.ep_datain !== 16'h0) begin testsFailed++; $display("[TB] FAIL clear_datain got=%h exp=0000", bus.ep_datain); end
      if (ovfCnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL clear_ovf got=%0d exp=0", ovfCnt); end
      pushOne(32'h1111_2222);
      testsRun++;
      if (bus.ep_datain !== 16'h2222) begin testsFailed++; $display("[TB] FAIL clear_newlow got=%h exp=2222", bus.ep_datain); end
      for (int i = 0; i < 2; i++) begin
         readOne(g, e);
         testsRun++;
         if (g !== e) begin testsFailed++; $display("[TB] FAIL clear_word%0d got=%h exp=%h", i, g, e); end
      end
   endtask

   task automatic test_underflow_reset();
      logic [15:0] g, e;
      for (int i = 0; i < 4; i++) begin
         readOne(g, e);
         testsRun++;
         if (g !== 16'h0) begin testsFailed++; $display("[TB] FAIL und_word%0d got=%h exp=0000", i, g); end
      end
      testsRun += 2;
      if (undCnt !== 16'(mUnd)) begin testsFailed++; $display("[TB] FAIL und_cnt got=%0d exp=%0d", undCnt, mUnd); end
      if (undCnt !== 16'd4) begin testsFailed++; $display("[TB] FAIL und_four got=%0d exp=4", undCnt); end
      for (int i = 0; i < 3; i++) begin
         bus.ep_blockstrobe = 1'b1;
         @(negedge clk);
         bus.ep_blockstrobe = 1'b0;
         @(negedge clk);
      end
      testsRun++;
      if (blkCnt !== 16'd3) begin testsFailed++; $display("[TB] FAIL blk_cnt got=%0d exp=3", blkCnt); end
      pushOne(32'h0F0F_F0F0);
      pushOne(32'h1E1E_E1E1);
      readOne(g, e);
      reset_n = 1'b0;
      #1;
      testsRun += 6;
      if (fillCnt !== 3'd0) begin testsFailed++; $display("[TB] FAIL async_fill got=%0d exp=0", fillCnt); end
      if (bus.ep_datain !== 16'h0) begin testsFailed++; $display("[TB] FAIL async_datain got=%h exp=0000", bus.ep_datain); end
      if (bus.ep_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_ready got=%b exp=0", bus.ep_ready); end
      if (undCnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL async_und got=%0d exp=0", undCnt); end
      if (blkCnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL async_blk got=%0d exp=0", blkCnt); end
      if (ovfFlag !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_ovf got=%b exp=0", ovfFlag); end
      @(negedge clk);
      reset_n = 1'b1;
      modelReset();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ready();
      test_enable();
      test_overflow();
      test_full_pop();
      test_clear();
      test_underflow_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule
